uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between several byte sources on the Tang Nano 9K stream interface: the protocol FSM's response bytes plus the per-channel data-return streams. It arbitrates among requesters with round-robin (optionally with a fixed-priority override for port 0). It drives the transmitter's `send_trig`/`send_data` pair and holds the byte stable for the whole frame. It sequences one frame at a time using the transmitter's `tx_bsy` flag.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requester ports, 2..8.
- `TX_GAP`, default 2: idle cycles inserted after `tx_bsy` falls before the next arbitration, 0..15.
- `BSY_TIMEOUT`, default 7: cycles to wait for `tx_bsy` to rise after a trigger before retrying, 2..15.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk` in 1: system clock (27 MHz).
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-port byte offered; held until accepted.
- `req_data` in NUM_REQ*8: port i byte in bits [8i+7:8i].
- `req_ready` out NUM_REQ: one-cycle acceptance pulse per port.
- `tx_send_trig` out 1: to transmitter `send_trig`.
- `tx_send_data` out 8: to transmitter `send_data`.
- `tx_bsy` in 1: from transmitter.
- `grant_id` out clog2(NUM_REQ): port owning the current frame.
- `busy` out 1: high in every state except IDLE.
- `retry_err` out 1: sticky; set on any busy-timeout retry.
- `frames_sent` out 16: count of completed frames.

## Operation
- FSM states: IDLE, TRIG, WAIT_BSY, WAIT_DONE, GAP.
- IDLE, when any `req_valid` is high:
  - select the winner `w`;
  - latch `req_data[w]` into `tx_send_data` and set `grant_id<=w`;
  - pulse `req_ready[w]` on the next cycle;
  - move the pointer to `w`; go to TRIG.
- IDLE with no valid request: stay in IDLE.
- Round-robin: search ports starting at pointer+1, wrapping modulo NUM_REQ. After reset the pointer is NUM_REQ-1, so port 0 is searched first.
- TRIG: `tx_send_trig`=1 for exactly one cycle. Clear the timeout counter. Go to WAIT_BSY.
- WAIT_BSY:
  - `tx_bsy`=1: go to WAIT_DONE.
  - Otherwise count cycles; when the count reaches BSY_TIMEOUT, set `retry_err` and go back to TRIG (same byte, same grant).
- WAIT_DONE: on `tx_bsy`=0, increment `frames_sent` (wraps 0xFFFF to 0x0000), then go to GAP, or to IDLE directly when TX_GAP=0.
- GAP: count TX_GAP cycles, then go to IDLE.
- `tx_send_data` changes only in IDLE on acceptance. The transmitter re-registers `send_data` every cycle, so this value must stay stable from capture until the frame completes.
- Requester rule: hold `req_valid`/`req_data` until the edge on which its `req_ready`=1; it may present a new byte afterwards.
- Requests that arrive in any non-IDLE state are not lost. They wait, and are not accepted until the next IDLE.
- `retry_err` is cleared only by `rst`.
- Reset mid-frame: all state returns to reset values immediately. The transmitter shares `rst`, so no partial frame continues.

## Timing
- Reset values:
  - `req_ready`=0, `tx_send_trig`=0, `tx_send_data`=8'h00;
  - `grant_id`=0, `busy`=0, `retry_err`=0, `frames_sent`=0;
  - state=IDLE, pointer=NUM_REQ-1.
- Request-to-trigger latency (cycle-by-cycle, from the edge C0 where IDLE sees a valid request):
  - C0: capture data and grant.
  - C1: `req_ready[w]`=1 and `tx_send_trig`=1 (state TRIG).
  - C2: WAIT_BSY; the transmitter raises `tx_bsy` at C2.
- End-of-frame to next acceptance: falling edge of `tx_bsy` + 1 (WAIT_DONE exit) + TX_GAP cycles.
- Throughput: one frame per transmitter frame period (91 cycles) + TX_GAP + 3 cycles.
- At most one `req_ready` bit is high in any cycle. `tx_send_trig` is never high while `tx_bsy`=1.

## Configuration
- `UART_TX_ARB_PRIO0_EN` defined:
  - port 0 wins whenever its `req_valid`=1, regardless of the pointer;
  - other ports use round-robin;
  - the pointer still updates to the winner.
- Not defined: pure round-robin for all ports, port 0 included.

## Test plan
- Single request: port 2 offers 8'hA5 → `req_ready[2]` pulses once; the transmitter sends A5; `frames_sent`=1; `busy` falls TX_GAP+1 cycles after `tx_bsy` falls.
- All four ports valid from reset, held continuously (no macro) → grant order 0,1,2,3,0; each byte sent intact and unmodified.
- Ports 1 and 3 valid, pointer=1 → port 3 served first, then port 1.
- Stubbed `tx_bsy` held at 0 → trigger repeats every BSY_TIMEOUT+1 cycles; `retry_err`=1; `tx_send_data` unchanged.
- `rst` asserted mid-frame (tx_cnt≈40) → next cycle all outputs at reset values; a fresh request afterwards completes normally.
- `UART_TX_ARB_PRIO0_EN` defined, ports 0 and 2 valid continuously → port 0 wins every arbitration and port 2 is starved. With port 0 idle, port 2 is served.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source / UART-transmitter bundle shared by uart_tx_arbiter (master side)
// and the requesters plus transmitter around it (slave side).
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_send_trig;
  logic [7:0]           tx_send_data;
  logic                 tx_bsy;
  logic [GW-1:0]        grant_id;
  logic                 busy;
  logic                 retry_err;
  logic [15:0]          frames_sent;

  modport master (
    input  req_valid, req_data, tx_bsy,
    output req_ready, tx_send_trig, tx_send_data, grant_id, busy, retry_err, frames_sent
  );

  modport slave (
    output req_valid, req_data, tx_bsy,
    input  req_ready, tx_send_trig, tx_send_data, grant_id, busy, retry_err, frames_sent
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_TX_ARB_PRIO0_EN to let port 0 override the round-robin order.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TX_GAP      = 2,
  parameter int unsigned BSY_TIMEOUT = 7
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_BSY, WAIT_DONE, GAP} state_t;

  state_t        state;
  logic [GW-1:0] ptr;
  logic [GW-1:0] win;
  logic [GW-1:0] idx;
  logic [7:0]    win_data;
  logic [3:0]    to_cnt;
  logic [3:0]    gap_cnt;

  // Scan from the farthest candidate back to ptr+1 so the nearest valid port wins.
  always_comb begin
    win = ptr;
    idx = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((32'(ptr) + k) % NUM_REQ);
      if (bus.req_valid[idx]) win = idx;
    end
`ifdef UART_TX_ARB_PRIO0_EN
    if (bus.req_valid[0]) win = '0;
`endif
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(win) == i) win_data = bus.req_data[i*8 +: 8];
    end
  end

  // Trigger and ready are set on the edge entering TRIG, so both are high for
  // exactly the TRIG cycle; a timeout re-enters TRIG with the same byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ptr              <= GW'(NUM_REQ - 1);
      to_cnt           <= '0;
      gap_cnt          <= '0;
      bus.req_ready    <= '0;
      bus.tx_send_trig <= 1'b0;
      bus.tx_send_data <= '0;
      bus.grant_id     <= '0;
      bus.busy         <= 1'b0;
      bus.retry_err    <= 1'b0;
      bus.frames_sent  <= '0;
    end else begin
      bus.req_ready    <= '0;
      bus.tx_send_trig <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            bus.tx_send_data <= win_data;
            bus.grant_id     <= win;
            bus.req_ready    <= NUM_REQ'(1) << win;
            bus.tx_send_trig <= 1'b1;
            bus.busy         <= 1'b1;
            ptr              <= win;
            state            <= TRIG;
          end
        end
        TRIG: begin
          to_cnt <= '0;
          state  <= WAIT_BSY;
        end
        WAIT_BSY: begin
          if (bus.tx_bsy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == 4'(BSY_TIMEOUT - 1)) begin
            bus.retry_err    <= 1'b1;
            bus.tx_send_trig <= 1'b1;
            state            <= TRIG;
          end else begin
            to_cnt <= to_cnt + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_bsy) begin
            bus.frames_sent <= bus.frames_sent + 16'd1;
            gap_cnt         <= '0;
            if (TX_GAP == 0) begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'(TX_GAP - 1)) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner sequences and
// randomized traffic against a queue-based round-robin reference model.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int TX_GAP      = 2;
  localparam int BSY_TIMEOUT = 7;
  localparam int FRAME       = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TX_GAP(TX_GAP),
    .BSY_TIMEOUT(BSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;

  // Transmitter stand-in: answers a trigger with a FRAME-cycle busy window.
  bit         xmit_en = 1'b1;
  int         xcnt;
  logic [7:0] xcap;
  logic [7:0] sent_q[$];
  int         stab_viol = 0;
  int         onehot_viol = 0;
  int         trig_bsy_viol = 0;

  always @(posedge clk) begin
    if (rst) begin
      bus.tx_bsy <= 1'b0;
      xcnt       <= 0;
    end else if (bus.tx_bsy) begin
      if (bus.tx_send_data !== xcap) stab_viol <= stab_viol + 1;
      if (xcnt == 1) begin
        bus.tx_bsy <= 1'b0;
        sent_q.push_back(xcap);
      end
      xcnt <= xcnt - 1;
    end else if (xmit_en && bus.tx_send_trig) begin
      bus.tx_bsy <= 1'b1;
      xcnt       <= FRAME;
      xcap       <= bus.tx_send_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!$onehot0(bus.req_ready)) onehot_viol <= onehot_viol + 1;
      if (bus.tx_send_trig && bus.tx_bsy) trig_bsy_viol <= trig_bsy_viol + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic expire(input string nm);
    n_total++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_byte(input int p, input logic [7:0] b);
    bus.req_data[p*8 +: 8] = b;
    bus.req_valid[p] = 1'b1;
  endtask

  task automatic wait_ready(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) expire(nm);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.tx_bsy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) expire(nm);
  endtask

  // Reference arbitration: first valid port after p, modulo NUM_REQ.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
`ifdef UART_TX_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    int                 exp_rr;
    int                 exp_pr;
  } vec_t;

  vec_t       tbl[12];
  logic [7:0] exp_q[$];
  logic [7:0] cur[NUM_REQ];

  initial begin
    int e;
    int n;
    int g;
    int w;
    int mptr;
    bit prev_busy;
    bit ok;
    logic [NUM_REQ-1:0] vec_prev;
    logic [7:0] b;

    tbl[0]  = '{4'b0100, 2, 2};
    tbl[1]  = '{4'b1010, 3, 3};
    tbl[2]  = '{4'b1010, 1, 1};
    tbl[3]  = '{4'b1010, 3, 3};
    tbl[4]  = '{4'b1010, 1, 1};
    tbl[5]  = '{4'b1111, 2, 0};
    tbl[6]  = '{4'b1001, 3, 0};
    tbl[7]  = '{4'b1001, 0, 0};
    tbl[8]  = '{4'b0110, 1, 1};
    tbl[9]  = '{4'b0110, 2, 2};
    tbl[10] = '{4'b0001, 0, 0};
    tbl[11] = '{4'b1000, 3, 3};

    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset state, with requests pending to show reset dominates.
    rst = 1'b1;
    bus.req_valid = '1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_trig", 32'(bus.tx_send_trig), 0);
    chk("rst_data", 32'(bus.tx_send_data), 0);
    chk("rst_grant", 32'(bus.grant_id), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_retry", 32'(bus.retry_err), 0);
    chk("rst_frames", 32'(bus.frames_sent), 0);
    bus.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    // Single request: cycle-exact latency and end-of-frame timing.
    sent_q.delete();
    set_byte(2, 8'hA5);
    @(negedge clk);
    chk("lat_ready", 32'(bus.req_ready), 32'h4);
    chk("lat_trig", 32'(bus.tx_send_trig), 1);
    chk("lat_busy", 32'(bus.busy), 1);
    chk("lat_grant", 32'(bus.grant_id), 2);
    chk("lat_data", 32'(bus.tx_send_data), 32'hA5);
    bus.req_valid = '0;
    @(negedge clk);
    chk("lat_ready_off", 32'(bus.req_ready), 0);
    chk("lat_trig_off", 32'(bus.tx_send_trig), 0);
    chk("lat_tx_bsy", 32'(bus.tx_bsy), 1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.tx_bsy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) expire("lat_frame_end");
    n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall_delay", 32'(n), 32'(TX_GAP + 1));
    chk("lat_frames", 32'(bus.frames_sent), 1);
    chk("lat_sent_cnt", 32'(sent_q.size()), 1);
    if (sent_q.size() > 0) chk("lat_sent_byte", 32'(sent_q[0]), 32'hA5);

    // Reset in the middle of a frame, then a fresh request.
    set_byte(3, 8'h5A);
    wait_ready("mid_ready");
    bus.req_valid = '0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tx_bsy && xcnt <= FRAME - 10) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) expire("mid_frame_reach");
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ready0", 32'(bus.req_ready), 0);
    chk("mid_trig0", 32'(bus.tx_send_trig), 0);
    chk("mid_data0", 32'(bus.tx_send_data), 0);
    chk("mid_grant0", 32'(bus.grant_id), 0);
    chk("mid_busy0", 32'(bus.busy), 0);
    chk("mid_frames0", 32'(bus.frames_sent), 0);
    chk("mid_tx_bsy0", 32'(bus.tx_bsy), 0);
    rst = 1'b0;
    sent_q.delete();
    set_byte(0, 8'h77);
    wait_ready("mid_fresh_ready");
    chk("mid_fresh_grant", 32'(bus.grant_id), 0);
    bus.req_valid = '0;
    wait_idle("mid_fresh_idle");
    chk("mid_fresh_frames", 32'(bus.frames_sent), 1);
    chk("mid_fresh_cnt", 32'(sent_q.size()), 1);
    if (sent_q.size() > 0) chk("mid_fresh_byte", 32'(sent_q[0]), 32'h77);

    // Transmitter never answers: periodic retries with a frozen byte.
    do_reset();
    xmit_en = 1'b0;
    set_byte(1, 8'h3C);
    wait_ready("to_ready");
    chk("to_retry_initial", 32'(bus.retry_err), 0);
    bus.req_valid = '0;
    for (int r = 0; r < 2; r++) begin
      n = 0;
      ok = 1'b0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (bus.tx_send_trig) begin
          n = i;
          ok = 1'b1;
          break;
        end
      end
      if (!ok) expire("to_retrigger");
      chk("to_period", 32'(n), 32'(BSY_TIMEOUT + 1));
      chk("to_retry_err", 32'(bus.retry_err), 1);
      chk("to_data_held", 32'(bus.tx_send_data), 32'h3C);
      chk("to_grant_held", 32'(bus.grant_id), 1);
    end
    xmit_en = 1'b1;
    wait_idle("to_recover");
    chk("to_frames", 32'(bus.frames_sent), 1);
    chk("to_retry_sticky", 32'(bus.retry_err), 1);
    do_reset();
    chk("to_retry_cleared", 32'(bus.retry_err), 0);

    // Vector table: one request pattern at a time, pointer carried across.
    do_reset();
    sent_q.delete();
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      for (int p = 0; p < NUM_REQ; p++)
        if (tbl[i].mask[p]) set_byte(p, 8'((p + 1) * 16 + i));
`ifdef UART_TX_ARB_PRIO0_EN
      e = tbl[i].exp_pr;
`else
      e = tbl[i].exp_rr;
`endif
      wait_ready("tbl_ready");
      chk("tbl_grant", 32'(bus.grant_id), 32'(e));
      chk("tbl_ready_bit", 32'(bus.req_ready), 32'(1) << e);
      chk("tbl_data", 32'(bus.tx_send_data), 32'((e + 1) * 16 + i));
      exp_q.push_back(8'((e + 1) * 16 + i));
      bus.req_valid = '0;
      wait_idle("tbl_idle");
    end
    chk("tbl_frames", 32'(bus.frames_sent), 12);
    chk("tbl_sent_cnt", 32'(sent_q.size()), 12);
    for (int i = 0; i < 12 && i < sent_q.size(); i++)
      chk("tbl_sent_byte", 32'(sent_q[i]), 32'(exp_q[i]));

    // Continuously held requests.
    do_reset();
    sent_q.delete();
    exp_q.delete();
`ifdef UART_TX_ARB_PRIO0_EN
    cur[0] = 8'hC0;
    cur[2] = 8'hC2;
    set_byte(0, cur[0]);
    set_byte(2, cur[2]);
    for (int k = 0; k < 4; k++) begin
      wait_ready("prio_ready");
      g = (k < 3) ? 0 : 2;
      chk("prio_grant", 32'(bus.grant_id), 32'(g));
      chk("prio_data", 32'(bus.tx_send_data), 32'(cur[g]));
      exp_q.push_back(cur[g]);
      if (k < 2) begin
        cur[0] = cur[0] + 8'h10;
        set_byte(0, cur[0]);
      end else begin
        bus.req_valid[0] = 1'b0;
      end
    end
    bus.req_valid = '0;
`else
    for (int p = 0; p < NUM_REQ; p++) begin
      cur[p] = 8'(8'hC0 + p);
      set_byte(p, cur[p]);
    end
    for (int k = 0; k < 5; k++) begin
      wait_ready("rr_ready");
      g = k % NUM_REQ;
      chk("rr_grant", 32'(bus.grant_id), 32'(g));
      chk("rr_data", 32'(bus.tx_send_data), 32'(cur[g]));
      exp_q.push_back(cur[g]);
      cur[g] = cur[g] + 8'h10;
      set_byte(g, cur[g]);
    end
    bus.req_valid = '0;
`endif
    wait_idle("hold_idle");
    chk("hold_sent_cnt", 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk("hold_sent_byte", 32'(sent_q[i]), 32'(exp_q[i]));

    // Randomized traffic against the reference model.
    do_reset();
    sent_q.delete();
    exp_q.delete();
    mptr = NUM_REQ - 1;
    prev_busy = 1'b0;
    vec_prev = '0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      if (vec_prev != '0 && !prev_busy) begin
        w = pick(vec_prev, mptr);
        chk("rand_ready", 32'(bus.req_ready), 32'(1) << w);
        chk("rand_grant", 32'(bus.grant_id), 32'(w));
        chk("rand_data", 32'(bus.tx_send_data), 32'(cur[w]));
        exp_q.push_back(cur[w]);
        mptr = w;
        if ($urandom_range(1, 0) == 1 && cyc < 2000) begin
          cur[w] = 8'($urandom);
          set_byte(w, cur[w]);
        end else begin
          bus.req_valid[w] = 1'b0;
        end
      end else if (bus.req_ready != '0) begin
        chk("rand_spurious_ready", 32'(bus.req_ready), 0);
      end
      if (cyc < 2000) begin
        for (int p = 0; p < NUM_REQ; p++) begin
          if (!bus.req_valid[p] && $urandom_range(5, 0) == 0) begin
            b = 8'($urandom);
            cur[p] = b;
            set_byte(p, b);
          end
        end
      end
      vec_prev = bus.req_valid;
      prev_busy = bus.busy;
    end
    wait_idle("rand_drain");
    chk("rand_all_served", 32'(bus.req_valid), 0);
    chk("rand_frames", 32'(bus.frames_sent), 32'(exp_q.size()));
    chk("rand_sent_cnt", 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk("rand_sent_byte", 32'(sent_q[i]), 32'(exp_q[i]));

    chk("data_stable_in_frame", 32'(stab_viol), 0);
    chk("ready_onehot", 32'(onehot_viol), 0);
    chk("trig_while_bsy", 32'(trig_bsy_viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
